img_channel_streamer: RTL

Multi-channel image readout sequencer that streams N_CHANNELS equally sized BRAM images (e.g. x/y gradient planes, scale-space levels) out as a byte stream to a UART transmitter over a valid/ready handshake. It generalises the two-channel X/Y dump to any channel count. It adds an optional per-channel header byte, offset-binary conversion of signed pixels, and an auto-advance or step (button-advance) mode. It sits between the processing BRAMs' read ports and `uart_tx`.

---
 rtl/img_channel_streamer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/img_channel_streamer.sv
// Streams N_CHANNELS equally sized BRAM images out as bytes over a valid/ready link.
// Each channel may be preceded by a header byte; channels advance automatically or on a button.
module img_channel_streamer #(
   parameter int unsigned WIDTH         = 64,
   parameter int unsigned HEIGHT        = 64,
   parameter int unsigned BIT_DEPTH     = 8,
   parameter int unsigned N_CHANNELS    = 2,
   parameter int unsigned BRAM_LATENCY  = 2,
   parameter int unsigned SEND_HEADER   = 1,
   parameter int unsigned SIGNED_OFFSET = 0,
   localparam int unsigned NPIX = WIDTH * HEIGHT,
   localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1,
   localparam int unsigned CW   = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
   input  logic                              clk_in,
   input  logic                              rst_in,
   input  logic                              start_in,
   input  logic                              step_mode_in,
   input  logic                              advance_in,
   input  logic                              abort_in,
   output logic [AW-1:0]                     rd_addr_out,
   output logic                              rd_en_out,
   input  logic [N_CHANNELS*BIT_DEPTH-1:0]   rd_data_in,
   output logic [7:0]                        tx_data_out,
   output logic                              tx_valid_out,
   input  logic                              tx_ready_in,
   output logic [CW-1:0]                     chan_out,
   output logic                              busy_out,
   output logic                              chan_done_out,
   output logic                              done_out
);

   typedef enum logic [2:0] {
      StIdle, StHeader, StFetch, StWaitRd, StSend, StChanEnd, StWaitAdv
   } state_e;

   localparam logic [AW-1:0] LastAddr = AW'(NPIX - 1);
   localparam logic [CW-1:0] LastChan = CW'(N_CHANNELS - 1);
   localparam logic [1:0]    LatMax   = 2'(BRAM_LATENCY - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [CW-1:0] chan_q, chan_d;
   logic [1:0]    lat_q, lat_d;
   logic          step_q, step_d;
   logic          rd_en_q, rd_en_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_valid_q, tx_valid_d;
   logic          busy_q, busy_d;
   logic          chan_done_q, chan_done_d;
   logic          done_q, done_d;

   logic                 begin_chan;
   logic [CW-1:0]        next_chan;
   int unsigned          rd_idx;
   logic [BIT_DEPTH-1:0] pix;
   logic [7:0]           pix_byte;

   always_comb begin
      rd_idx = int'(chan_q) * BIT_DEPTH;
      pix    = rd_data_in[rd_idx +: BIT_DEPTH];
      // Two's complement to offset binary: flip the sign bit.
      if (SIGNED_OFFSET != 0) pix[BIT_DEPTH-1] = ~pix[BIT_DEPTH-1];
      pix_byte = 8'(pix);
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      chan_d      = chan_q;
      lat_d       = lat_q;
      step_d      = step_q;
      rd_en_d     = 1'b0;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      busy_d      = busy_q;
      chan_done_d = 1'b0;
      done_d      = 1'b0;
      begin_chan  = 1'b0;
      next_chan   = '0;

      unique case (state_q)
         StIdle: begin
            if (start_in) begin
               step_d     = step_mode_in;
               busy_d     = 1'b1;
               begin_chan = 1'b1;
            end
         end
         StHeader: begin
            if (tx_ready_in) begin
               tx_valid_d = 1'b0;
               rd_en_d    = 1'b1;
               state_d    = StFetch;
            end
         end
         StFetch: begin
            lat_d   = '0;
            state_d = StWaitRd;
         end
         StWaitRd: begin
            if (lat_q == LatMax) begin
               tx_data_d  = pix_byte;
               tx_valid_d = 1'b1;
               state_d    = StSend;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         StSend: begin
            if (tx_ready_in) begin
               tx_valid_d = 1'b0;
               if (addr_q != LastAddr) begin
                  addr_d  = addr_q + AW'(1);
                  rd_en_d = 1'b1;
                  state_d = StFetch;
               end else begin
                  chan_done_d = 1'b1;
                  done_d      = (chan_q == LastChan);
                  state_d     = StChanEnd;
               end
            end
         end
         StChanEnd: begin
            if (chan_q == LastChan) begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end else if (step_q) begin
               state_d = StWaitAdv;
            end else begin
               begin_chan = 1'b1;
               next_chan  = chan_q + CW'(1);
            end
         end
         StWaitAdv: begin
            if (advance_in) begin
               begin_chan = 1'b1;
               next_chan  = chan_q + CW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      if (begin_chan) begin
         chan_d = next_chan;
         addr_d = '0;
         if (SEND_HEADER != 0) begin
            tx_data_d  = 8'hA0 | 8'(next_chan);
            tx_valid_d = 1'b1;
            state_d    = StHeader;
         end else begin
            rd_en_d = 1'b1;
            state_d = StFetch;
         end
      end

      // Abort overrides everything, including the end-of-channel pulses.
      if (abort_in) begin
         state_d     = StIdle;
         busy_d      = 1'b0;
         tx_valid_d  = 1'b0;
         rd_en_d     = 1'b0;
         chan_done_d = 1'b0;
         done_d      = 1'b0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         chan_q      <= '0;
         lat_q       <= '0;
         step_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         chan_done_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         chan_q      <= chan_d;
         lat_q       <= lat_d;
         step_q      <= step_d;
         rd_en_q     <= rd_en_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         busy_q      <= busy_d;
         chan_done_q <= chan_done_d;
         done_q      <= done_d;
      end
   end

   assign rd_addr_out   = addr_q;
   assign rd_en_out     = rd_en_q;
   assign tx_data_out   = tx_data_q;
   assign tx_valid_out  = tx_valid_q;
   assign chan_out      = chan_q;
   assign busy_out      = busy_q;
   assign chan_done_out = chan_done_q;
   assign done_out      = done_q;

endmodule
